uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single system UART transmitter between `NumReq` byte-stream requesters, such as the per-core console ports of a multi-core Vicuna system. A requester holds the transmitter for a whole text line, so console output from different cores never interleaves mid-line. The block sits between the requesters and the UART TX byte interface inside the demo system top. Grants rotate round-robin between lines.

## Interface
- `NumReq`, default 4: number of requesters; must be at least 2.
- `TimeoutCycles`, default 1024: idle-cycle limit for a held grant; used only when the timeout feature is compiled in.
- `clk_i`, input, 1: system clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `req_valid_i`, input, NumReq: per-requester byte valid.
- `req_data_i`, input, NumReq×8: per-requester byte.
- `req_ready_o`, output, NumReq: per-requester byte accepted.
- `tx_valid_o`, output, 1: byte valid to the UART.
- `tx_data_o`, output, 8: byte to the UART.
- `tx_ready_i`, input, 1: UART accepts a byte.
- `owner_o`, output, $clog2(NumReq): index of the current grant holder; valid only while `busy_o` is 1.
- `busy_o`, output, 1: a grant is held (state LOCKED).

## Operation
- States: IDLE and LOCKED.
  - Registers: `owner` and `rr_ptr`, each $clog2(NumReq) bits.
  - Timeout builds only: `idle_cnt`, $clog2(TimeoutCycles+1) bits.
- In IDLE:
  - All `req_ready_o` = 0, `tx_valid_o` = 0, `tx_data_o` = 0.
  - If any `req_valid_i` is set, select the first set index found by searching upward from `rr_ptr`, wrapping modulo NumReq.
  - Register that index as `owner` and go to LOCKED.
- In LOCKED, a combinational pass-through to the owner:
  - `tx_valid_o` = `req_valid_i[owner]`.
  - `tx_data_o` = `req_data_i[owner]`.
  - `req_ready_o[owner]` = `tx_ready_i`; every other `req_ready_o` bit = 0.
- A transfer happens on any cycle where `tx_valid_o` and `tx_ready_i` are both 1.
- When a transfer carries byte 0x0A (LF):
  - The state goes to IDLE.
  - `rr_ptr` = (owner+1) mod NumReq.
- Requesters follow the valid/ready rules: once valid is raised, data stays stable and valid stays high until ready.
- The arbiter does not check these rules. It is transparent to the requester within a granted line.
- Bytes from non-owners stall (their ready stays 0) and are never dropped.
- Boundary conditions:
  - If all requesters are valid in IDLE, the one at `rr_ptr` wins.
  - If the owner drops valid mid-line, the grant is held (without the timeout feature, indefinitely).
  - If LF is the owner's only requesting byte and it lands in the first LOCKED cycle, the block is LOCKED for exactly one cycle.
  - `rr_ptr` wraps from NumReq-1 to 0.
- Reset, including mid-line: state = IDLE, `owner` = 0, `rr_ptr` = 0, `idle_cnt` = 0. All outputs read 0.

## Timing
- Requester valid in IDLE at cycle n → LOCKED at n+1; the first byte can transfer at n+1.
- LF transfer at cycle m → IDLE at m+1 → the next owner is LOCKED at m+2. There is one dead cycle between lines.
- The data path is combinational, with zero added latency within a line. Throughput is one byte per cycle while `tx_ready_i` holds.
- `busy_o` and `owner_o` are registered and change the cycle after the transition decision.

## Configuration
- Macro `UART_TX_ARB_TIMEOUT_EN`.
- When defined:
  - `idle_cnt` counts LOCKED cycles with no transfer and clears on every transfer and on entry to LOCKED.
  - When `idle_cnt` reaches `TimeoutCycles`, the next cycle is IDLE with `rr_ptr` = owner+1. This stops a requester that never sends LF from starving the others.
  - A transfer on the same cycle as the threshold takes priority: the counter clears and the lock is kept.
- When undefined: no counter is built, and a grant is released only by LF.

## Structure
- Package `uart_tx_arb_pkg` holds:
  - state enum `uart_arb_state_e` (ARB_IDLE, ARB_LOCKED);
  - constant `UartLineEnd` = 8'h0A.
- Sub-module `rr_pick`: a purely combinational rotate-priority picker.
  - Inputs: request vector, pointer.
  - Outputs: any-request flag, winner index.
  - Instantiated once.

## Test plan
- Only requester 2 valid, sending "hi\n" (0x68 0x69 0x0A) with `tx_ready_i`=1 → `owner_o`=2; the UART sees 3 bytes on consecutive cycles; `busy_o` drops the cycle after the LF transfer.
- All 4 requesters valid from reset, each sending a 2-byte line ending in LF → grant order 0,1,2,3; no byte interleaving; exactly 1 idle cycle between lines.
- Owner 1 mid-line while `tx_ready_i` toggles 1,0,0,1 → `req_ready_o[1]` mirrors `tx_ready_i`; `req_ready_o` of requester 3 (valid) stays 0; no byte lost or duplicated.
- `rst_ni` asserted mid-line for requester 0 → `tx_valid_o`=0, `busy_o`=0 immediately; after release, the first grant goes to the lowest valid index.
- With `UART_TX_ARB_TIMEOUT_EN`, `TimeoutCycles`=16: owner 0 sends 0x41, then drops valid; requester 1 is valid → release after 16 idle cycles; `owner_o`=1 two cycles later.
- Without the macro, same stimulus → owner 0 holds the grant for 1000 cycles; requester 1 is never granted.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the line-granular UART transmit arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } uart_arb_state_e;

  localparam logic [7:0] UartLineEnd = 8'h0A;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr_i, wrapping.
module rr_pick #(
  parameter int NumReq = 4
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic                      any_o,
  output logic [$clog2(NumReq)-1:0] idx_o
);

  localparam int IdxW = $clog2(NumReq);

  logic [IdxW-1:0] cand;

  // Scan from the far end down so the lowest offset from ptr_i is written last and wins.
  always_comb begin
    any_o = |req_i;
    idx_o = ptr_i;
    cand  = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand = IdxW'((int'(ptr_i) + k) % NumReq);
      if (req_i[cand]) idx_o = cand;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX byte port between NumReq requesters, one text line per grant.
// Optional idle-grant release is compiled in with UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NumReq        = 4,
  parameter int TimeoutCycles = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq-1:0]         req_valid_i,
  input  logic [NumReq-1:0][7:0]    req_data_i,
  output logic [NumReq-1:0]         req_ready_o,
  output logic                      tx_valid_o,
  output logic [7:0]                tx_data_o,
  input  logic                      tx_ready_i,
  output logic [$clog2(NumReq)-1:0] owner_o,
  output logic                      busy_o
);

  localparam int IdxW = $clog2(NumReq);

  if (NumReq < 2 || TimeoutCycles < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: NumReq must be >= 2 and TimeoutCycles >= 1");
  end

  uart_arb_state_e state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

  logic            any_req;
  logic [IdxW-1:0] pick_idx;
  logic            owner_valid;
  logic [7:0]      owner_data;
  logic            xfer;
  logic            line_end;
  logic            timeout;
  logic [IdxW-1:0] next_ptr;

  rr_pick #(
    .NumReq(NumReq)
  ) u_rr_pick (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .any_o (any_req),
    .idx_o (pick_idx)
  );

  // Data path is a pure mux onto the owner; nothing from the owner is registered.
  always_comb begin
    owner_valid = req_valid_i[owner_q];
    owner_data  = req_data_i[owner_q];
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    req_ready_o = '0;
    if (state_q == ARB_LOCKED) begin
      tx_valid_o           = owner_valid;
      tx_data_o            = owner_data;
      req_ready_o[owner_q] = tx_ready_i;
    end
    xfer     = (state_q == ARB_LOCKED) && owner_valid && tx_ready_i;
    line_end = xfer && (owner_data == UartLineEnd);
    next_ptr = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + IdxW'(1);
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

  // A transfer in the threshold cycle keeps the lock; only a stalled cycle releases it.
  always_comb begin
    timeout    = (state_q == ARB_LOCKED) && !xfer && (idle_cnt_q == CntW'(TimeoutCycles));
    idle_cnt_d = '0;
    if ((state_q == ARB_LOCKED) && !xfer && !timeout) idle_cnt_d = idle_cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idle_cnt_q <= '0;
    else         idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d = ARB_LOCKED;
          owner_d = pick_idx;
        end
      end
      ARB_LOCKED: begin
        if (line_end || timeout) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign busy_o  = (state_q == ARB_LOCKED);
  assign owner_o = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed line scenarios plus random traffic.
// Build with UART_TX_ARB_TIMEOUT_EN to exercise the idle-grant release path.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int T  = 16;
  localparam int IW = 2;
  localparam logic [7:0] LF = 8'h0A;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req_valid;
  logic [N-1:0][7:0]   req_data;
  logic [N-1:0]        req_ready;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                tx_ready;
  logic [IW-1:0]       owner;
  logic                busy;

  uart_tx_arbiter #(
    .NumReq(N),
    .TimeoutCycles(T)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_ready_i  (tx_ready),
    .owner_o     (owner),
    .busy_o      (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters and check helper ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- sources (scoreboard of bytes still owed) ----------------
  logic [7:0] src_q[N][$];
  int         ready_pat[$];
  int         vprob = 100;
  int         rprob = 100;

  function automatic int pending();
    int s = 0;
    for (int r = 0; r < N; r++) s += src_q[r].size();
    return s;
  endfunction

  // ---------------- behavioural model ----------------
  logic m_locked = 1'b0;
  int   m_owner  = 0;
  int   m_rr     = 0;
  int   m_idle   = 0;
  logic m_xfer   = 1'b0;
  int   m_who    = 0;

  function automatic int pick_next(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return ptr;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_locked <= 1'b0;
      m_owner  <= 0;
      m_rr     <= 0;
      m_idle   <= 0;
      m_xfer   <= 1'b0;
      m_who    <= 0;
    end else begin
      m_xfer <= m_locked && req_valid[m_owner] && tx_ready;
      m_who  <= m_owner;
      if (!m_locked) begin
        if (req_valid != '0) begin
          m_locked <= 1'b1;
          m_owner  <= pick_next(req_valid, m_rr);
          m_idle   <= 0;
        end
      end else if (req_valid[m_owner] && tx_ready) begin
        m_idle <= 0;
        if (req_data[m_owner] == LF) begin
          m_locked <= 1'b0;
          m_rr     <= (m_owner + 1) % N;
        end
      end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (m_idle == T) begin
          m_locked <= 1'b0;
          m_rr     <= (m_owner + 1) % N;
        end else begin
          m_idle <= m_idle + 1;
        end
`else
        m_idle <= m_idle + 1;
`endif
      end
    end
  end

  // ---------------- logs for literal expectations ----------------
  int         cyc = 0;
  logic       prev_locked = 1'b0;
  int         grant_q[$];
  int         grant_cyc_q[$];
  logic [7:0] xb_q[$];
  int         xc_q[$];
  int         xw_q[$];
  int         fall_cyc = -1;

  function automatic int xb_at(input int i);
    return (i < xb_q.size()) ? int'(xb_q[i]) : -1;
  endfunction
  function automatic int xc_at(input int i);
    return (i < xc_q.size()) ? xc_q[i] : -1;
  endfunction
  function automatic int xw_at(input int i);
    return (i < xw_q.size()) ? xw_q[i] : -1;
  endfunction
  function automatic int g_at(input int i);
    return (i < grant_q.size()) ? grant_q[i] : -1;
  endfunction
  function automatic int gc_at(input int i);
    return (i < grant_cyc_q.size()) ? grant_cyc_q[i] : -1;
  endfunction

  task automatic clear_logs();
    grant_q.delete();
    grant_cyc_q.delete();
    xb_q.delete();
    xc_q.delete();
    xw_q.delete();
    fall_cyc = -1;
  endtask

  // ---------------- compare process ----------------
  logic         exp_busy;
  logic         exp_tv;
  logic [7:0]   exp_td;
  logic [N-1:0] exp_rdy;

  always @(negedge clk) begin
    cyc++;
    exp_busy = m_locked;
    exp_tv   = m_locked && req_valid[m_owner];
    exp_td   = m_locked ? req_data[m_owner] : 8'h00;
    exp_rdy  = '0;
    if (m_locked) exp_rdy[m_owner] = tx_ready;
    chk("busy", busy, exp_busy);
    chk("tx_valid", tx_valid, exp_tv);
    chk("tx_data", tx_data, exp_td);
    chk("req_ready", req_ready, exp_rdy);
    if (m_locked) chk("owner", owner, m_owner);
    else if (!rst_n) chk("owner_rst", owner, 0);
    if (exp_tv && tx_ready) begin
      if (src_q[m_owner].size() == 0) chk("sb_src_nonempty", src_q[m_owner].size(), 1);
      else chk("sb_byte", tx_data, src_q[m_owner][0]);
      xb_q.push_back(tx_data);
      xc_q.push_back(cyc);
      xw_q.push_back(m_owner);
    end
    if (m_locked && !prev_locked) begin
      grant_q.push_back(m_owner);
      grant_cyc_q.push_back(cyc);
    end
    if (!m_locked && prev_locked) fall_cyc = cyc;
    prev_locked = m_locked;
  end

  // ---------------- driver ----------------
  task automatic raise_valids();
    for (int r = 0; r < N; r++) begin
      if (!req_valid[r] && src_q[r].size() > 0 && $urandom_range(0, 99) < vprob) begin
        req_valid[r] = 1'b1;
        req_data[r]  = src_q[r][0];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (m_xfer) begin
      void'(src_q[m_who].pop_front());
      req_valid[m_who] = 1'b0;
    end
    raise_valids();
    if (ready_pat.size() > 0) tx_ready = ready_pat.pop_front() != 0;
    else tx_ready = $urandom_range(0, 99) < rprob;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int r = 0; r < N; r++) src_q[r].delete();
    req_valid = '0;
    step();
    step();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((pending() != 0 || m_locked) && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", pending(), 0);
    step();
    step();
  endtask

  // ---------------- stimulus ----------------
  int exp_bytes;
  int base;
  int len;

  initial begin
    req_valid = '0;
    req_data  = '0;
    tx_ready  = 1'b0;

    // A: single requester 2 sends "hi\n"
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    clear_logs();
    vprob = 100;
    rprob = 100;
    src_q[2] = '{8'h68, 8'h69, LF};
    wait_drain(50);
    chk("a_grants", grant_q.size(), 1);
    chk("a_owner", g_at(0), 2);
    chk("a_b0", xb_at(0), 32'h68);
    chk("a_b1", xb_at(1), 32'h69);
    chk("a_b2", xb_at(2), 32'h0A);
    chk("a_first_lat", xc_at(0), gc_at(0));
    chk("a_consec1", xc_at(1) - xc_at(0), 1);
    chk("a_consec2", xc_at(2) - xc_at(1), 1);
    chk("a_busy_fall", fall_cyc, xc_at(2) + 1);

    // B: all four valid out of reset, 2-byte lines
    do_reset();
    for (int r = 0; r < N; r++) src_q[r] = '{8'h41 + 8'(r), LF};
    step();
    clear_logs();
    rst_n = 1'b1;
    wait_drain(100);
    for (int i = 0; i < N; i++) chk("b_grant_order", g_at(i), i);
    for (int i = 0; i < 2 * N; i++) begin
      chk("b_who", xw_at(i), i / 2);
      chk("b_spacing", xc_at(i) - xc_at(0), (i / 2) * 3 + (i % 2));
    end

    // C: owner 1 mid-line while ready toggles; requester 3 waits
    clear_logs();
    src_q[1] = '{8'h61, 8'h62, 8'h63, LF};
    src_q[3] = '{8'h7A, LF};
    ready_pat = '{1, 1, 0, 0, 1};
    wait_drain(100);
    chk("c_grant0", g_at(0), 1);
    chk("c_grant1", g_at(1), 3);
    chk("c_count", xb_q.size(), 6);
    chk("c_b0", xb_at(0), 32'h61);
    chk("c_b1", xb_at(1), 32'h62);
    chk("c_b4", xb_at(4), 32'h7A);
    chk("c_stall_gap", xc_at(1) - xc_at(0), 3);
    chk("c_who3", xw_at(3), 1);
    chk("c_who4", xw_at(4), 3);

    // D: reset in the middle of requester 0's line
    clear_logs();
    src_q[0] = '{8'h78, 8'h79, 8'h7A, LF};
    for (int i = 0; i < 20 && xb_q.size() == 0; i++) step();
    chk("d_started", xw_at(0), 0);
    rst_n = 1'b0;
    #1;
    chk("d_rst_tx_valid", tx_valid, 0);
    chk("d_rst_busy", busy, 0);
    src_q[0].delete();
    req_valid[0] = 1'b0;
    src_q[2] = '{8'h31, LF};
    src_q[3] = '{8'h32, LF};
    step();
    step();
    clear_logs();
    rst_n = 1'b1;
    wait_drain(100);
    chk("d_grant0", g_at(0), 2);
    chk("d_grant1", g_at(1), 3);

    // Random traffic on all requesters
    clear_logs();
    vprob = 70;
    rprob = 70;
    exp_bytes = 0;
    for (int r = 0; r < N; r++) begin
      for (int l = 0; l < 4; l++) begin
        len = $urandom_range(1, 5);
        for (int b = 0; b < len; b++) src_q[r].push_back(8'($urandom_range(8'h20, 8'h7E)));
        src_q[r].push_back(LF);
        exp_bytes += len + 1;
      end
    end
    wait_drain(3000);
    chk("rand_bytes", xb_q.size(), exp_bytes);

    // E: owner 0 sends one byte then goes quiet; requester 1 waits
    do_reset();
    vprob = 100;
    rprob = 100;
    clear_logs();
    rst_n = 1'b1;
    src_q[0] = '{8'h41};
    src_q[1] = '{8'h42, LF};
`ifdef UART_TX_ARB_TIMEOUT_EN
    wait_drain(200);
    chk("e_grant0", g_at(0), 0);
    chk("e_grant1", g_at(1), 1);
    chk("e_b0", xb_at(0), 32'h41);
    chk("e_release", fall_cyc - xc_at(0), T + 2);
    chk("e_regrant", gc_at(1) - xc_at(0), T + 3);
`else
    repeat (1000) step();
    chk("e_hold_busy", busy, 1);
    chk("e_hold_owner", owner, 0);
    chk("e_hold_grants", grant_q.size(), 1);
    chk("e_b0", xb_at(0), 32'h41);
    chk("e_req1_waiting", src_q[1].size(), 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
